// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - Breakout playfield geometry, derived pixel limits, mode/phase types and helpers.
package breakout_pkg;

  localparam int TILE_SIZE           = 8;
  localparam int CEILING_Y_TILE      = 9;
  localparam int LEFT_WALL_X_TILE    = 0;
  localparam int RIGHT_WALL_X_TILE   = 99;
  localparam int PADDLE_Y_TILE       = 73;
  localparam int SCREEN_W            = 800;
  localparam int SCREEN_H            = 600;
  localparam int PADDLE_LENGTH_PIXEL = 60;

  // Playfield spans PLAY_X_MIN up to (not including) PLAY_X_END.
  localparam int PLAY_X_MIN   = (LEFT_WALL_X_TILE + 1) * TILE_SIZE;
  localparam int PLAY_X_END   = RIGHT_WALL_X_TILE * TILE_SIZE;
  localparam int TOP_LIMIT_Y  = (CEILING_Y_TILE + 1) * TILE_SIZE;
  localparam int PADDLE_TOP_Y = PADDLE_Y_TILE * TILE_SIZE;

  typedef enum logic [1:0] {
    MODE_SERVE,
    MODE_PLAY,
    MODE_GAME_OVER
  } game_mode_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_PADDLE,
    PH_BALL_X,
    PH_BALL_Y,
    PH_COLLIDE,
    PH_COMMIT
  } phase_t;

  function automatic logic signed [10:0] to_s(input logic [9:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic [9:0] clamp_px(input logic signed [10:0] v,
                                          input logic signed [10:0] lo,
                                          input logic signed [10:0] hi);
    if (v < lo) return lo[9:0];
    if (v > hi) return hi[9:0];
    return v[9:0];
  endfunction

endpackage

// File: rtl/breakout_game_controller_rising_edge_detect.sv
// rtl/breakout_game_controller_rising_edge_detect.sv - Single-cycle pulse on a 0->1 transition of a CLK-synchronous level.
module rising_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic PULSE
);

  logic r_prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_prev <= 1'b0;
    else       r_prev <= IN;
  end

  assign PULSE = IN & ~r_prev;

endmodule

// File: rtl/breakout_game_controller.sv
// rtl/breakout_game_controller.sv - Per-frame Breakout paddle/ball/lives sequencer with atomic output commit.
// Define BREAKOUT_AUTOPILOT_EN to let the paddle track the ball and auto-serve.
module breakout_game_controller #(
  parameter int PADDLE_LENGTH_PIXEL = breakout_pkg::PADDLE_LENGTH_PIXEL,
  parameter int PADDLE_SPEED        = 4,
  parameter int BALL_SPEED          = 2,
  parameter int BALL_SIZE_PIXEL     = 8,
  parameter int START_LIVES         = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSYNC,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_LAUNCH,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic [9:0] BALL_X_PIXEL,
  output logic [9:0] BALL_Y_PIXEL,
  output logic [1:0] LIVES,
  output logic       GAME_OVER,
  output logic       UPDATE_BUSY
);
  import breakout_pkg::*;

  localparam logic signed [10:0] S_X_MIN      = 11'(PLAY_X_MIN);
  localparam logic signed [10:0] S_PAD_MAX    = 11'(PLAY_X_END - PADDLE_LENGTH_PIXEL);
  localparam logic signed [10:0] S_BALL_X_MAX = 11'(PLAY_X_END - BALL_SIZE_PIXEL);
  localparam logic signed [10:0] S_TOP_Y      = 11'(TOP_LIMIT_Y);
  localparam logic signed [10:0] S_PAD_Y      = 11'(PADDLE_TOP_Y);
  localparam logic signed [10:0] S_FLOOR_Y    = 11'(SCREEN_H);
  localparam logic signed [10:0] S_PAD_LEN    = 11'(PADDLE_LENGTH_PIXEL);
  localparam logic signed [10:0] S_PAD_SPD    = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] S_BALL_SPD   = 11'(BALL_SPEED);
  localparam logic signed [10:0] S_BALL_SIZE  = 11'(BALL_SIZE_PIXEL);
  localparam logic [9:0] BALL_OFS   = 10'((PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2);
  localparam logic [9:0] REST_Y     = 10'(PADDLE_TOP_Y - BALL_SIZE_PIXEL);
  localparam logic [9:0] PAD_CENTER = 10'((SCREEN_W - PADDLE_LENGTH_PIXEL) / 2);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

  phase_t     r_phase, w_phase_next;
  game_mode_t r_mode;
  logic [9:0] r_pad_x, r_ball_x, r_ball_y, r_old_y;
  logic       r_dx_neg, r_dy_pos;
  logic [1:0] r_lives;
  logic       r_launch_pending, r_launch_go;
  logic [9:0] r_out_pad_x, r_out_ball_x, r_out_ball_y;
  logic [1:0] r_out_lives;
  logic       r_out_game_over;

  logic              w_tick, w_launch_edge, w_start;
  logic [9:0]        w_pad_next;
  logic              w_serve_launch;
  logic signed [10:0] w_nx, w_ny;
  logic              w_hit, w_lost;

  rising_edge_detect u_vsync_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (VSYNC),
    .PULSE (w_tick)
  );

  rising_edge_detect u_launch_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (BTN_LAUNCH),
    .PULSE (w_launch_edge)
  );

  assign w_start = w_tick && (r_phase == PH_IDLE);

`ifdef BREAKOUT_AUTOPILOT_EN
  logic signed [10:0] w_target;
  logic               w_unused_btn;
  assign w_unused_btn   = BTN_LEFT ^ BTN_RIGHT;
  assign w_target       = to_s(clamp_px(to_s(r_ball_x) - to_s(BALL_OFS), S_X_MIN, S_PAD_MAX));
  // Clamping the target into a +/-speed window around the paddle gives the bounded step.
  assign w_pad_next     = clamp_px(w_target, to_s(r_pad_x) - S_PAD_SPD, to_s(r_pad_x) + S_PAD_SPD);
  assign w_serve_launch = 1'b1;
`else
  always_comb begin
    w_pad_next = r_pad_x;
    if (BTN_LEFT && !BTN_RIGHT)
      w_pad_next = clamp_px(to_s(r_pad_x) - S_PAD_SPD, S_X_MIN, S_PAD_MAX);
    else if (BTN_RIGHT && !BTN_LEFT)
      w_pad_next = clamp_px(to_s(r_pad_x) + S_PAD_SPD, S_X_MIN, S_PAD_MAX);
  end
  assign w_serve_launch = r_launch_go;
`endif

  assign w_nx = r_dx_neg ? to_s(r_ball_x) - S_BALL_SPD : to_s(r_ball_x) + S_BALL_SPD;
  assign w_ny = r_dy_pos ? to_s(r_ball_y) + S_BALL_SPD : to_s(r_ball_y) - S_BALL_SPD;

  // Evaluated in COLLIDE, after BALL_Y has moved r_ball_y to the new position.
  assign w_hit = r_dy_pos
              && (to_s(r_old_y) + S_BALL_SIZE <= S_PAD_Y)
              && (to_s(r_ball_y) + S_BALL_SIZE >= S_PAD_Y)
              && (to_s(r_ball_x) + S_BALL_SIZE > to_s(r_pad_x))
              && (to_s(r_ball_x) < to_s(r_pad_x) + S_PAD_LEN);
  assign w_lost = to_s(r_ball_y) >= S_FLOOR_Y;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_phase <= PH_IDLE;
    else       r_phase <= w_phase_next;
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      PH_IDLE:    if (w_tick) w_phase_next = PH_PADDLE;
      PH_PADDLE:  w_phase_next = PH_BALL_X;
      PH_BALL_X:  w_phase_next = PH_BALL_Y;
      PH_BALL_Y:  w_phase_next = PH_COLLIDE;
      PH_COLLIDE: w_phase_next = PH_COMMIT;
      PH_COMMIT:  w_phase_next = PH_IDLE;
      default:    w_phase_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mode           <= MODE_SERVE;
      r_pad_x          <= PAD_CENTER;
      r_ball_x         <= PAD_CENTER + BALL_OFS;
      r_ball_y         <= REST_Y;
      r_old_y          <= REST_Y;
      r_dx_neg         <= 1'b0;
      r_dy_pos         <= 1'b0;
      r_lives          <= LIVES_INIT;
      r_launch_pending <= 1'b0;
      r_launch_go      <= 1'b0;
      r_out_pad_x      <= PAD_CENTER;
      r_out_ball_x     <= PAD_CENTER + BALL_OFS;
      r_out_ball_y     <= REST_Y;
      r_out_lives      <= LIVES_INIT;
      r_out_game_over  <= 1'b0;
    end else begin
      if (w_start) begin
        r_launch_go      <= r_launch_pending;
        r_launch_pending <= w_launch_edge;
      end else if (w_launch_edge) begin
        r_launch_pending <= 1'b1;
      end

      case (r_phase)
        PH_PADDLE: begin
          if (r_mode == MODE_GAME_OVER) begin
            if (r_launch_go) begin
              r_lives  <= LIVES_INIT;
              r_mode   <= MODE_SERVE;
              r_pad_x  <= PAD_CENTER;
              r_ball_x <= PAD_CENTER + BALL_OFS;
              r_ball_y <= REST_Y;
            end
          end else begin
            r_pad_x <= w_pad_next;
            if (r_mode == MODE_SERVE) begin
              r_ball_x <= w_pad_next + BALL_OFS;
              r_ball_y <= REST_Y;
              if (w_serve_launch) begin
                r_mode   <= MODE_PLAY;
                r_dx_neg <= 1'b0;
                r_dy_pos <= 1'b0;
              end
            end
          end
        end
        PH_BALL_X: if (r_mode == MODE_PLAY) begin
          if (w_nx <= S_X_MIN) begin
            r_ball_x <= S_X_MIN[9:0];
            r_dx_neg <= 1'b0;
          end else if (w_nx >= S_BALL_X_MAX) begin
            r_ball_x <= S_BALL_X_MAX[9:0];
            r_dx_neg <= 1'b1;
          end else begin
            r_ball_x <= w_nx[9:0];
          end
        end
        PH_BALL_Y: if (r_mode == MODE_PLAY) begin
          r_old_y <= r_ball_y;
          if (w_ny <= S_TOP_Y) begin
            r_ball_y <= S_TOP_Y[9:0];
            r_dy_pos <= 1'b1;
          end else begin
            r_ball_y <= w_ny[9:0];
          end
        end
        PH_COLLIDE: if (r_mode == MODE_PLAY) begin
          if (w_hit) begin
            r_ball_y <= REST_Y;
            r_dy_pos <= 1'b0;
          end else if (w_lost) begin
            if (r_lives == 2'd1) begin
              r_lives <= 2'd0;
              r_mode  <= MODE_GAME_OVER;
            end else begin
              r_lives  <= r_lives - 2'd1;
              r_mode   <= MODE_SERVE;
              r_ball_x <= r_pad_x + BALL_OFS;
              r_ball_y <= REST_Y;
            end
          end
        end
        PH_COMMIT: begin
          r_out_pad_x     <= r_pad_x;
          r_out_ball_x    <= r_ball_x;
          r_out_ball_y    <= r_ball_y;
          r_out_lives     <= r_lives;
          r_out_game_over <= (r_mode == MODE_GAME_OVER);
        end
        default: ;
      endcase
    end
  end

  assign PADDLE_X_PIXEL = r_out_pad_x;
  assign BALL_X_PIXEL   = r_out_ball_x;
  assign BALL_Y_PIXEL   = r_out_ball_y;
  assign LIVES          = r_out_lives;
  assign GAME_OVER      = r_out_game_over;
  assign UPDATE_BUSY    = (r_phase != PH_IDLE);

endmodule

// File: tb/tb_breakout_game_controller.sv
// tb/tb_breakout_game_controller.sv - Directed self-checking bench for breakout_game_controller.
module tb_breakout_game_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_launch = 1'b0;
  logic [9:0] pad_x, ball_x, ball_y;
  logic [1:0] lives;
  logic       game_over, busy;

  int n_checks = 0;
  int n_errors = 0;
  int frames;

  always #5 clk = ~clk;

  breakout_game_controller dut (
    .CLK            (clk),
    .RESET          (rst),
    .VSYNC          (vsync),
    .BTN_LEFT       (btn_left),
    .BTN_RIGHT      (btn_right),
    .BTN_LAUNCH     (btn_launch),
    .PADDLE_X_PIXEL (pad_x),
    .BALL_X_PIXEL   (ball_x),
    .BALL_Y_PIXEL   (ball_y),
    .LIVES          (lives),
    .GAME_OVER      (game_over),
    .UPDATE_BUSY    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int p, input int bx, input int by,
                             input int lv, input int go);
    check({tag, ".paddle"}, 32'(pad_x), p);
    check({tag, ".ball_x"}, 32'(ball_x), bx);
    check({tag, ".ball_y"}, 32'(ball_y), by);
    check({tag, ".lives"}, 32'(lives), lv);
    check({tag, ".game_over"}, 32'(game_over), go);
  endtask

  task automatic frame();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic frames_n(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_launch();
    btn_launch = 1'b1;
    @(negedge clk);
    btn_launch = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_until_lives(input int limit, output int n);
    logic [1:0] start_lives;
    start_lives = lives;
    n = 0;
    while (lives == start_lives && n < limit) begin
      frame();
      n++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset", 370, 396, 576, 3, 0);
    check("reset.busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      frame();
      check_state("idle_frame", 370, 396, 576, 3, 0);
    end

    btn_right = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    check("lat.busy_on", 32'(busy), 1);
    repeat (4) @(negedge clk);
    check("lat.old_paddle", 32'(pad_x), 370);
    @(negedge clk);
    check("lat.new_paddle", 32'(pad_x), 374);
    check("lat.busy_off", 32'(busy), 0);
    check("lat.ball_follow", 32'(ball_x), 400);
    repeat (2) @(negedge clk);
    for (int i = 2; i <= 100; i++) begin
      frame();
      check("right_ramp", 32'(pad_x), (370 + 4 * i > 732) ? 732 : 370 + 4 * i);
    end

    btn_right = 1'b0;
    btn_left  = 1'b1;
    frames_n(200);
    check_state("left_sat", 8, 34, 576, 3, 0);
    btn_right = 1'b1;
    frames_n(3);
    check("both_held", 32'(pad_x), 8);
    btn_left  = 1'b0;
    btn_right = 1'b0;

    do_reset();
    pulse_launch();
    frame();
    check_state("launch", 370, 398, 574, 3, 0);
    btn_left = 1'b1;
    frames_n(50);
    btn_left = 1'b0;
    check_state("play_left", 170, 498, 474, 3, 0);
    frames_n(142);
    check_state("near_wall", 170, 782, 190, 3, 0);
    frame();
    check_state("wall_hit", 170, 784, 188, 3, 0);
    frame();
    check_state("wall_back", 170, 782, 186, 3, 0);
    frames_n(52);
    check_state("near_ceiling", 170, 678, 82, 3, 0);
    frame();
    check_state("ceiling_hit", 170, 676, 80, 3, 0);
    frame();
    check_state("ceiling_back", 170, 674, 82, 3, 0);
    frames_n(246);
    check_state("near_paddle", 170, 182, 574, 3, 0);
    frame();
    check_state("paddle_hit", 170, 180, 576, 3, 0);
    frame();
    check_state("paddle_back", 170, 178, 574, 3, 0);

    run_until_lives(1000, frames);
    check("miss1.frames", 32'(frames), 507);
    check_state("miss1", 170, 196, 576, 2, 0);

    btn_left = 1'b1;
    frames_n(41);
    btn_left = 1'b0;
    check_state("serve_at_wall", 8, 34, 576, 2, 0);
    pulse_launch();
    run_until_lives(1000, frames);
    check("miss2.frames", 32'(frames), 508);
    check_state("miss2", 8, 34, 576, 1, 0);
    pulse_launch();
    run_until_lives(1000, frames);
    check("miss3.frames", 32'(frames), 508);
    check_state("miss3", 8, 518, 600, 0, 1);

    btn_right = 1'b1;
    frames_n(3);
    btn_right = 1'b0;
    check_state("frozen", 8, 518, 600, 0, 1);
    pulse_launch();
    frame();
    check_state("restart", 370, 396, 576, 3, 0);

    btn_right = 1'b1;
    frames_n(2);
    check_state("pre_reset", 378, 404, 576, 3, 0);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    check("mid.busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_state("async_reset", 370, 396, 576, 3, 0);
    check("async_reset.busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_commit.paddle", 32'(pad_x), 370);
    check("no_commit.busy", 32'(busy), 0);
    frame();
    check_state("post_reset_frame", 374, 400, 576, 3, 0);
    btn_right = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/breakout_game_controller.md
Name: breakout_game_controller

Overview:
- Per-frame game-state sequencer for the Breakout display path. Owns the paddle X position consumed by the game renderer, plus ball position, lives and game mode.
- Wakes once per frame on the rising edge of the renderer's VSYNC and steps paddle and ball through a short phase FSM.
- Commits all outputs atomically, so the renderer never sees a half-updated frame.

Parameters:
- PADDLE_LENGTH_PIXEL, 60, paddle width in pixels; must match the renderer's value.
- PADDLE_SPEED, 4, paddle pixels moved per frame.
- BALL_SPEED, 2, ball pixels per axis per frame.
- BALL_SIZE_PIXEL, 8, ball edge length in pixels (one tile).
- START_LIVES, 3, lives after reset or restart; range 1..3.

Ports:
- CLK  in  1  pixel clock; same clock that drives the renderer.
- RESET  in  1  asynchronous, active-high reset.
- VSYNC  in  1  renderer's VSYNC output; synchronous to CLK.
- BTN_LEFT  in  1  move paddle left (level).
- BTN_RIGHT  in  1  move paddle right (level).
- BTN_LAUNCH  in  1  serve or restart (edge-detected).
- PADDLE_X_PIXEL  out  10  paddle left edge, fed to the renderer.
- BALL_X_PIXEL  out  10  ball left edge.
- BALL_Y_PIXEL  out  10  ball top edge.
- LIVES  out  2  remaining lives.
- GAME_OVER  out  1  high while in GAME_OVER mode.
- UPDATE_BUSY  out  1  high while the phase FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high; it clears every register immediately, including in the middle of an update.
- Reset values:
  - PADDLE_X = 370; BALL = (396, 576); LIVES = START_LIVES.
  - GAME_OVER = 0; UPDATE_BUSY = 0; mode = SERVE; dx = +, dy = −.
  - launch_pending = 0; VSYNC and BTN_LAUNCH history registers = 0.
- Geometry (pixels):
  - Playfield x is 8..791; wall tiles are 0 and 99.
  - Top limit y = 80, immediately below ceiling tile 9.
  - Paddle top y = 584 (tile 73).
  - Paddle X range 8..(792 − PADDLE_LENGTH_PIXEL). Ball X range 8..784. Ball Y minimum 80.
- Frame tick: single-cycle pulse when VSYNC is 1 and its previous-cycle value is 0. A tick is ignored while UPDATE_BUSY = 1.
- Launch latch: a BTN_LAUNCH rising edge sets launch_pending. A tick consumes and clears it.
- Phase FSM, one cycle per state: IDLE → PADDLE → BALL_X → BALL_Y → COLLIDE → COMMIT → IDLE.
  - UPDATE_BUSY = 1 in every state except IDLE.
  - Outputs change only in the cycle after COMMIT: 6 cycles after the tick cycle.
- PADDLE phase:
  - Left only: x = max(8, x − PADDLE_SPEED).
  - Right only: x = min(max, x + PADDLE_SPEED).
  - Both or neither: no change.
  - Runs in every mode except GAME_OVER.
- SERVE mode:
  - Ball rides the paddle: x = paddle + (PADDLE_LENGTH_PIXEL − BALL_SIZE_PIXEL)/2 (26 at defaults); y = 576.
  - launch_pending set → mode PLAY, dx = +BALL_SPEED, dy = −BALL_SPEED.
- PLAY, BALL_X phase:
  - nx = x + dx, computed in 11-bit signed arithmetic.
  - nx ≤ 8: x = 8, dx = +. nx ≥ 784: x = 784, dx = −.
- PLAY, BALL_Y phase:
  - ny = y + dy. ny ≤ 80: y = 80, dy = +.
- PLAY, COLLIDE phase:
  - Paddle hit when all hold: dy > 0; old y + 8 ≤ 584; ny + 8 ≥ 584; ball x + 8 > paddle; ball x < paddle + PADDLE_LENGTH_PIXEL. Result: y = 576, dy = −.
  - Otherwise, if ny ≥ 600: life lost.
    - LIVES = 1 → LIVES = 0, mode GAME_OVER.
    - Else LIVES − 1, mode SERVE.
  - Corner case (wall and ceiling in the same frame): both axes reflect independently.
- GAME_OVER mode:
  - Ball and paddle frozen.
  - launch_pending at a tick → LIVES = START_LIVES, mode SERVE, paddle re-centered to 370.
- COMMIT: copies the working registers to all outputs in one cycle.

Optional Feature:
- Macro: BREAKOUT_AUTOPILOT_EN.
- Defined: PADDLE ignores BTN_LEFT and BTN_RIGHT. Target = ball x − 26; the paddle steps toward it by at most PADDLE_SPEED per frame, clamped to the paddle range. SERVE auto-launches on the first tick.
- Undefined: button control only; no autopilot logic is synthesized.

Decomposition:
- Shared package breakout_pkg:
  - Geometry constants: TILE_SIZE 8, CEILING_Y_TILE 9, LEFT_WALL_X_TILE 0, RIGHT_WALL_X_TILE 99, PADDLE_Y_TILE 73, SCREEN_W 800, SCREEN_H 600, PADDLE_LENGTH_PIXEL.
  - Derived pixel limits.
  - Typedefs: game_mode_t (SERVE, PLAY, GAME_OVER) and phase_t (IDLE, PADDLE, BALL_X, BALL_Y, COLLIDE, COMMIT).
- Sub-module rising_edge_detect (CLK, RESET, IN, PULSE): instantiated for VSYNC and BTN_LAUNCH.

Test Plan:
1. Reset, then 3 ticks with no input → PADDLE_X = 370, ball (396, 576), LIVES = 3, GAME_OVER = 0; outputs update 6 cycles after each VSYNC rise.
2. BTN_RIGHT held for 100 ticks → paddle climbs by 4 per frame and saturates at 732. BTN_LEFT held for 200 ticks → saturates at 8. Both held → no change.
3. Launch pulse, then 1 tick → ball (398, 574), mode PLAY. Ball at x = 783, dx + → x = 784, next frame 782.
4. Ball at y = 81, dy − → y = 80, then 82. Ball at (400, 575), dy +, paddle 370 → y = 576, dy −.
5. Paddle at 8, ball falling at x = 600 → LIVES 3 → 2 and mode SERVE, ball re-attached at paddle + 26. After the third miss → LIVES = 0, GAME_OVER = 1, frozen. Launch → LIVES = 3, GAME_OVER = 0.
6. RESET asserted while UPDATE_BUSY = 1 (BALL_Y phase) → all outputs return to reset values within the same cycle, no COMMIT occurs, and the next tick proceeds normally.
